mem_bus_master: RTL
===================

Name: mem_bus_master

Overview:
- CPU-side initiator for the shared single-port RAM bus: mem_read, mem_write, a 9-bit address and a bidirectional 32-bit data bus.
- Accepts one word request at a time from the control unit, holds it in internal MAR/MDR registers, and runs a setup/strobe/recover sequence on the bus.
- The RAM write is level-sensitive, so the block guarantees:
  - read and write are never both asserted;
  - address and data are stable for a full cycle before and after every strobe.
- Sits between the datapath (MAR/MDR loads) and the RAM.

Parameters:
- ADDR_W, 9, address width of the RAM bus.
- DATA_W, 32, data word width.
- MEM_DEPTH, 256, number of valid words; addresses >= MEM_DEPTH are rejected.
- STROBE_CYC, 1, cycles the read/write strobe stays high (legal range 1..15).

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous active-high reset.
- req  in  1  request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr_in  in  ADDR_W  word address; sampled with req.
- wdata  in  DATA_W  write data; sampled with req.
- rdata  out  DATA_W  last successfully read word.
- busy  out  1  high from the cycle after acceptance through RECOVER.
- done  out  1  one-cycle pulse in RECOVER (or ERR).
- err  out  1  valid with done; 1 = address out of range, no bus cycle issued.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_addr  out  ADDR_W  RAM address (MAR).
- mem_data  inout  DATA_W  RAM data bus; driven only during write sequences, else high-Z.

Behaviour:
- All outputs are registered.
- Reset state (clear=1, asynchronous): state=IDLE, mem_read=0, mem_write=0, mem_data released to Z, mem_addr=0, rdata=0, busy=0, done=0, err=0, strobe counter=0.
- States: IDLE, SETUP, STROBE, RECOVER, ERR.
- IDLE:
  - req=1 with addr_in < MEM_DEPTH: latch addr_in into MAR, we into op, wdata into MDR; next state SETUP.
  - req=1 with addr_in >= MEM_DEPTH: next state ERR, no strobes.
  - req=0: stay.
- SETUP (1 cycle):
  - mem_addr=MAR, strobes low, busy=1.
  - Write: mem_data driven with MDR from this cycle onward.
  - Load the counter with STROBE_CYC-1; next state STROBE.
- STROBE:
  - Exactly one strobe high: mem_read when op=read, mem_write when op=write.
  - Counter decrements each cycle; the state lasts STROBE_CYC cycles.
  - Read: rdata captures mem_data on the last STROBE edge (counter=0).
  - Next state RECOVER when counter=0.
- RECOVER (1 cycle):
  - Strobes low, mem_addr held; for a write, mem_data is still driven (hold time).
  - done=1, err=0, busy=1.
  - Next state IDLE; mem_data is released on entry to IDLE.
- ERR (1 cycle): done=1, err=1, busy=0, no bus activity; next state IDLE.
- Latency with STROBE_CYC=1:
  - Request sampled at edge 0.
  - SETUP in cycle 1, STROBE in cycle 2, done in cycle 3.
  - New rdata is visible in cycle 3.
  - The next request can be sampled at edge 4.
  - Total is STROBE_CYC+2 cycles to done.
- req while not IDLE is ignored (no queuing); the control unit must hold req or re-issue it after done.
- mem_read & mem_write = 1 must never occur in any state, including reset release.
- mem_data must never be driven while mem_read=1.
- Reset mid-operation: strobes drop and the bus releases asynchronously. No done pulse. rdata is cleared to 0, not partially updated.
- A failed or aborted read leaves rdata at its prior value (apart from clear).
- mem_addr keeps its last value in IDLE.
- clear deasserting with req=1 already high: the request is accepted on the first edge after deassertion.

Decomposition:
- Shared package (cpu_pkg): state encoding enum (IDLE/SETUP/STROBE/RECOVER/ERR), ADDR_W/DATA_W/MEM_DEPTH defaults, op encoding constants OP_READ=0/OP_WRITE=1.
- No sub-module; the tristate driver is a single continuous assignment inside the block, gated by a registered drive-enable.

Test Plan:
- Write then read: req we=1 addr=0x055 wdata=0x00000002, then req we=0 addr=0x055. Required:
  - mem_write high exactly 1 cycle, with data stable in SETUP..RECOVER;
  - the read returns rdata=0x00000002 with done at cycle 3.
- Out of range: req addr=0x100 (256). Required:
  - done=1, err=1 one cycle after acceptance;
  - mem_read/mem_write never rise, mem_data stays Z.
- Ignored request: req pulsed again in STROBE with addr=0x05A. Required: ignored; only one bus cycle and one done pulse occur.
- Reset mid-write: clear asserted during STROBE of a write to 0x023. Required:
  - mem_write=0 and mem_data=Z in the same cycle (before the next edge);
  - busy=0, no done pulse.
- STROBE_CYC=3, read of preloaded 0x91180023 at addr 0. Required:
  - mem_read high exactly 3 cycles;
  - done at cycle 5, rdata=0x91180023.
- Checker over all runs: never (mem_read & mem_write); never (mem_read & mem_data driven).

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding, bus defaults and op codes for the memory bus master
package cpu_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, ERR} state_t;

    localparam int DEF_ADDR_W    = 9;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MEM_DEPTH = 256;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_bus_master.sv
// mem_bus_master: one-word-at-a-time setup/strobe/recover initiator for the single-port RAM bus
module mem_bus_master
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int STROBE_CYC = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
);

    state_t state, next_state;
    logic op, op_n, drive_en, in_range, accept, last;
    logic read_n, write_n, drive_n, busy_n, done_n, err_n;
    logic [DATA_W-1:0] mdr;
    logic [3:0] cnt;

    assign in_range = {1'b0, addr_in} < (ADDR_W + 1)'(MEM_DEPTH);
    assign accept   = state == IDLE && req && in_range;
    assign op_n     = accept ? we : op;
    assign last     = state == STROBE && cnt == 4'd0;

    // bus released whenever the registered drive-enable is low, including async clear
    assign mem_data = drive_en ? mdr : 'z;

    // state register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= next_state;
    end

    // next state: requests only seen in IDLE, strobe lasts until the counter hits zero
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = !req ? IDLE : in_range ? SETUP : ERR;
            SETUP:   next_state = STROBE;
            STROBE:  next_state = last ? RECOVER : STROBE;
            default: next_state = IDLE;
        endcase
    end

    // output decode from the upcoming state so every bus pin comes straight from a flop
    always_comb begin
        read_n  = next_state == STROBE && op_n == OP_READ;
        write_n = next_state == STROBE && op_n == OP_WRITE;
        busy_n  = next_state inside {SETUP, STROBE, RECOVER};
        drive_n = busy_n && op_n == OP_WRITE;
        done_n  = next_state inside {RECOVER, ERR};
        err_n   = next_state == ERR;
    end

    // MAR/MDR/op capture, strobe counter, read capture and registered outputs
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            op        <= OP_READ;
            mdr       <= '0;
            mem_addr  <= '0;
            cnt       <= '0;
            rdata     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            drive_en  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                op       <= we;
                mdr      <= wdata;
                mem_addr <= addr_in;
            end
            cnt       <= state == SETUP ? 4'(STROBE_CYC - 1) : state == STROBE ? cnt - 4'd1 : cnt;
            if (last && op == OP_READ) rdata <= mem_data;
            mem_read  <= read_n;
            mem_write <= write_n;
            drive_en  <= drive_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

endmodule
